// File: rtl/food_layer_receiver.sv
// Food-layer pellet bitmap: commits software rows, serves video reads, applies pellet eats.
// Tracks the live pellet count and pulses level_clear when the last pellet is eaten.
module food_layer_receiver #(
   parameter logic [4:0] IDLE_CODE = 5'h1F,
   parameter int         CNT_W     = 10
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [31:0]      food_layer_data,
   input  logic [4:0]       food_layer_wr,
   input  logic             rd_en,
   input  logic [4:0]       rd_row,
   input  logic [4:0]       rd_col,
   output logic             rd_pellet,
   input  logic             eat_valid,
   input  logic [4:0]       eat_row,
   input  logic [4:0]       eat_col,
   output logic             eat_hit,
   output logic [CNT_W-1:0] pellet_count,
   output logic             level_clear,
   output logic             commit_done
);

   localparam int                  ROWS     = 31;
   localparam logic [4:0]          LAST_ROW = 5'd30;
   localparam logic signed [CNT_W:0] C_ONE  = 1;

   typedef enum logic [1:0] {
      WAIT_RELEASE,
      IDLE,
      LATCH
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_capture;
   logic                w_commit;
   logic                w_commit_ok;

   logic [31:0]         r_mem [0:ROWS-1];
   logic [31:0]         r_hold_data;
   logic [4:0]          r_hold_row;
   logic [CNT_W-1:0]    r_count;
   logic                r_rd_pellet;
   logic                r_eat_hit;
   logic                r_level_clear;
   logic                r_commit_done;

   logic                w_eat_bit;
   logic                w_eat_ok;
   logic [5:0]          w_pc_new;
   logic [5:0]          w_pc_old;
   logic signed [CNT_W:0] w_cnt_sum;
   logic                w_cnt_zero;

   function automatic logic [5:0] f_popcnt(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         WAIT_RELEASE: begin
            if (food_layer_wr == IDLE_CODE) w_state_nxt = IDLE;
         end
         IDLE: begin
            if (food_layer_wr != IDLE_CODE) begin
               w_capture   = 1'b1;
               w_state_nxt = LATCH;
            end
         end
         LATCH: begin
            w_commit    = 1'b1;
            w_state_nxt = WAIT_RELEASE;
         end
         default: w_state_nxt = WAIT_RELEASE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state <= WAIT_RELEASE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_hold_data <= '0;
         r_hold_row  <= '0;
      end else if (w_capture) begin
         r_hold_data <= food_layer_data;
         r_hold_row  <= food_layer_wr;
      end
   end

   // Row 31 has no storage; only matters if IDLE_CODE is overridden.
   assign w_commit_ok = w_commit && (r_hold_row <= LAST_ROW);

   // An eat on the row being committed loses to the software data.
   assign w_eat_bit = (eat_row <= LAST_ROW) ? r_mem[eat_row][eat_col] : 1'b0;
   assign w_eat_ok  = eat_valid && w_eat_bit &&
                      !(w_commit_ok && (eat_row == r_hold_row));

   assign w_pc_new = f_popcnt(r_hold_data);
   assign w_pc_old = f_popcnt(r_mem[r_hold_row]);

   always_comb begin
      w_cnt_sum = $signed({1'b0, r_count});
      if (w_commit_ok) begin
         w_cnt_sum = w_cnt_sum + $signed({{(CNT_W-5){1'b0}}, w_pc_new})
                               - $signed({{(CNT_W-5){1'b0}}, w_pc_old});
      end
      if (w_eat_ok) begin
         w_cnt_sum = w_cnt_sum - C_ONE;
      end
   end

   assign w_cnt_zero = (w_cnt_sum == '0);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < ROWS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_commit_ok) r_mem[r_hold_row] <= r_hold_data;
         if (w_eat_ok)    r_mem[eat_row][eat_col] <= 1'b0;
      end
   end

   // Reads sample the array before this edge's writes land.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_rd_pellet <= 1'b0;
      end else if (rd_en) begin
         r_rd_pellet <= (rd_row <= LAST_ROW) ? r_mem[rd_row][rd_col] : 1'b0;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_count       <= '0;
         r_eat_hit     <= 1'b0;
         r_level_clear <= 1'b0;
         r_commit_done <= 1'b0;
      end else begin
         r_count       <= w_cnt_sum[CNT_W-1:0];
         r_eat_hit     <= w_eat_ok;
         r_level_clear <= w_eat_ok && w_cnt_zero;
         r_commit_done <= w_commit_ok;
      end
   end

   assign rd_pellet    = r_rd_pellet;
   assign eat_hit      = r_eat_hit;
   assign level_clear  = r_level_clear;
   assign commit_done  = r_commit_done;
   assign pellet_count = r_count;

endmodule

// File: doc/food_layer_receiver.md
# food_layer_receiver

Fabric-side receiver for the food-layer PIO channel driven by the Nios II software. It commits 32-bit pellet rows into a 31×32 flop-based bitmap. It serves single-pellet reads to the video pipeline and applies pellet-eaten clears from game logic. It also maintains a live pellet count and raises a level-clear pulse when the last pellet is eaten.

## Interface

Parameters:
- `IDLE_CODE`, default 5'h1F: `food_layer_wr` value meaning "no write"; rows 0..30 are usable.
- `CNT_W`, default 10: pellet counter width; max content is 31×32 = 992.

Ports:
- `clk_clk`, in, 1: system clock, same domain as the PIO.
- `reset_reset_n`, in, 1: asynchronous, active-low reset.
- `food_layer_data`, in, 32: row data; bit c is the pellet at column c.
- `food_layer_wr`, in, 5: row index to commit, or `IDLE_CODE`.
- `rd_en`, in, 1: video read request.
- `rd_row`, in, 5: video read row.
- `rd_col`, in, 5: video read column.
- `rd_pellet`, out, 1: registered pellet bit.
- `eat_valid`, in, 1: one-cycle request to clear a pellet.
- `eat_row`, in, 5: row of the pellet to clear.
- `eat_col`, in, 5: column of the pellet to clear.
- `eat_hit`, out, 1: one-cycle pulse; the eaten pellet was present.
- `pellet_count`, out, `CNT_W`: number of set bits in the bitmap.
- `level_clear`, out, 1: one-cycle pulse when an eat brings the count to 0.
- `commit_done`, out, 1: one-cycle pulse when a row write completes.

## Operation

Protocol:
- Software writes `food_layer_data` first.
- Software then writes the row index to `food_layer_wr`.
- Software returns `food_layer_wr` to `IDLE_CODE` before the next row.

Commit FSM has three states:
- `WAIT_RELEASE`: entered from reset. Moves to `IDLE` when `food_layer_wr == IDLE_CODE`.
- `IDLE`: when `food_layer_wr != IDLE_CODE`, capture the data into `hold_data` and the row into `hold_row`, then move to `LATCH`.
- `LATCH`: perform the commit below, then move to `WAIT_RELEASE`.

Commit actions in `LATCH`:
- Write `hold_data` to `mem[hold_row]`.
- Update `pellet_count += popcount(hold_data) - popcount(old mem[hold_row])`.
- Pulse `commit_done`.

Commit boundary rules:
- A row index of 31 can never be committed, because it equals `IDLE_CODE`.
- Holding `food_layer_wr` non-idle commits exactly once.
- Changing `food_layer_wr` directly from one row to another without passing through idle commits nothing.

Eat handling:
- If `mem[eat_row][eat_col]` is 1: clear the bit, decrement `pellet_count`, and pulse `eat_hit`.
- If the count becomes 0 through this eat, also pulse `level_clear` in the same cycle.
- If the bit is 0 or `eat_row == 31`: no effect.

Simultaneous eat and commit:
- Eat on the same row as `hold_row` in the `LATCH` cycle: the eat is dropped and there is no `eat_hit`. Software data is authoritative.
- Eat on a different row in the same cycle: both proceed, and the count adds both deltas in one update.

Reads:
- `rd_pellet` is registered from `mem[rd_row][rd_col]` when `rd_en` is high; otherwise it holds its value.
- A read of `rd_row == 31` returns 0.
- Reads are read-before-write: a read in the same cycle as a write to that row returns the old value.

Reset, asynchronous:
- All `mem` bits = 0.
- `pellet_count` = 0.
- `rd_pellet`, `eat_hit`, `level_clear` and `commit_done` = 0.
- FSM = `WAIT_RELEASE`; hold registers = 0.
- Reset in the middle of a commit aborts it; nothing is written.

Arithmetic:
- Popcounts are 6 bits wide.
- The count update is computed at `CNT_W + 1` bits signed, then truncated to `CNT_W`.
- By construction the count never underflows or overflows.

## Timing

- `food_layer_wr` becomes a row index in the cycle sampled at edge N (FSM in `IDLE`). The hold registers load at edge N.
- At edge N+1 the memory and `pellet_count` are updated and `commit_done` is high for cycle N+1.
- Data must be stable at edge N only.
- `food_layer_wr` returning to idle at edge M puts the FSM in `IDLE` at edge M+1.
- Eat: request sampled at edge E; the bit clears, the count updates, and `eat_hit` / `level_clear` assert, all registered at edge E.
- Read: 1-cycle latency; request at edge R, `rd_pellet` is valid after edge R.
- Throughput: one eat per cycle, one read per cycle, and one commit per ≥3 cycles (`IDLE` → `LATCH` → `WAIT_RELEASE` → `IDLE`).

## Test plan

- **Reset, then first commit:** reset, drive `wr=3`, `data=32'hFFFF_FFFF` with no prior idle → no commit and `count=0`. Then drive `wr=31`, then `wr=3` → `commit_done` 2 cycles after the `wr` change and `count=32`.
- **Row overwrite:** commit `row5=32'h0000_00FF`, then commit `row5=32'h0000_000F` → `count=8`, then 4; reading `row5 col7` returns 0.
- **Eat and clear:** with only `row0=32'h1` loaded, eat `(0,0)` → `eat_hit=1`, `level_clear=1`, `count=0`; repeating the eat gives no pulses.
- **Same-row collision:** eat `(2,4)` in the `LATCH` cycle of a commit to `row2=32'h10` → eat dropped, `count=1`, bit set. The same test with eat on `row7` (bit set) → both applied, net count correct.
- **Hold and row-to-row:** hold `wr=9` for 20 cycles → exactly one `commit_done`. Change `wr` 9→10 directly → no commit.
- **Read-before-write and row 31:** read `row5` in the commit cycle of `row5` → old bit returned. Any read of row 31 returns 0.
